// File: rtl/glyph_renderer.sv
// Renders one scaled 5x5 glyph box: drives the ROM row address during the glyph's scan band,
// latches the row pattern at line start and serialises it MSB-first as a registered pixel_on.
module glyph_renderer #(
  parameter int GLYPH_W    = 5,
  parameter int GLYPH_H    = 5,
  parameter int SCALE_LOG2 = 3,
  parameter int CW         = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pix_tick,
  input  logic               video_on,
  input  logic [CW-1:0]      pixel_x,
  input  logic [CW-1:0]      pixel_y,
  input  logic [CW-1:0]      origin_x,
  input  logic [CW-1:0]      origin_y,
  output logic [2:0]         glyph_row_addr,
  input  logic [GLYPH_W-1:0] glyph_row_data,
  output logic               pixel_on,
  output logic               drawing
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    DRAW  = 2'd2
  } state_t;

  localparam int BIT_W = $clog2(GLYPH_W + 1);
  localparam logic [CW:0]         BAND_H   = (CW+1)'(GLYPH_H << SCALE_LOG2);
  localparam logic [BIT_W-1:0]    LAST_BIT = BIT_W'(GLYPH_W);
  localparam logic [SCALE_LOG2-1:0] SUB_ONE = SCALE_LOG2'(1);
  localparam logic [SCALE_LOG2-1:0] SUB_MAX = '1;

  state_t                state, state_n;
  logic [GLYPH_W-1:0]    row_buf, row_buf_n, row_shift;
  logic [CW-1:0]         x_lat, x_lat_n;
  logic [SCALE_LOG2-1:0] sub_cnt, sub_n;
  logic [BIT_W-1:0]      bit_cnt, bit_n;
  logic                  pixel_on_n;

  // One extra bit keeps origin_y + band height from wrapping near the top of the coordinate range.
  logic [CW:0] py_ext, oy_ext, band_end, row_off;
  logic        in_band;

  assign py_ext   = {1'b0, pixel_y};
  assign oy_ext   = {1'b0, origin_y};
  assign band_end = oy_ext + BAND_H;
  assign row_off  = py_ext - oy_ext;
  assign in_band  = (py_ext >= oy_ext) && (py_ext < band_end);

  assign glyph_row_addr = in_band ? 3'(row_off >> SCALE_LOG2) : 3'd0;
  assign drawing        = (state == DRAW);

  // Current glyph column is brought to the MSB so the bit select stays a constant index.
  assign row_shift = row_buf << bit_cnt;

  // NOTE: every always_comb output gets a default first so no path leaves a latch behind.
  always_comb begin
    state_n    = state;
    row_buf_n  = row_buf;
    x_lat_n    = x_lat;
    sub_n      = sub_cnt;
    bit_n      = bit_cnt;
    pixel_on_n = 1'b0;

    unique case (state)
      IDLE: begin
        if (pixel_x == '0 && video_on && in_band) begin
          row_buf_n = glyph_row_data;
          x_lat_n   = origin_x;
          if (origin_x == '0) begin
            state_n    = DRAW;
            pixel_on_n = glyph_row_data[GLYPH_W-1];
            sub_n      = SUB_ONE;
            bit_n      = '0;
          end else begin
            state_n = ARMED;
          end
        end
      end
      ARMED: begin
        if (pixel_x == x_lat) begin
          state_n    = DRAW;
          pixel_on_n = row_buf[GLYPH_W-1];
          sub_n      = SUB_ONE;
          bit_n      = '0;
        end else if (pixel_x == '0) begin
          state_n = IDLE;
        end
      end
      DRAW: begin
        if (bit_cnt == LAST_BIT) begin
          state_n = IDLE;
        end else begin
          pixel_on_n = row_shift[GLYPH_W-1];
          sub_n      = sub_cnt + SUB_ONE;
          if (sub_cnt == SUB_MAX) bit_n = bit_cnt + BIT_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase

    // Leaving the visible area aborts any draw; the box is simply truncated at the right edge.
    if (!video_on) begin
      state_n    = IDLE;
      pixel_on_n = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      pixel_on <= 1'b0;
      row_buf  <= '0;
      x_lat    <= '0;
      sub_cnt  <= '0;
      bit_cnt  <= '0;
    end else if (pix_tick) begin
      state    <= state_n;
      pixel_on <= pixel_on_n;
      row_buf  <= row_buf_n;
      x_lat    <= x_lat_n;
      sub_cnt  <= sub_n;
      bit_cnt  <= bit_n;
    end
  end

endmodule

// File: tb/tb_glyph_renderer.sv
// Scoreboard bench for glyph_renderer: scan lines are generated pixel by pixel, a line-level
// model predicts pixel_on/drawing/row address, and a monitor compares every clock.
module tb_glyph_renderer;

  localparam int CW    = 10;
  localparam int H_VIS = 160;
  localparam int H_TOT = 180;
  localparam int BOX   = 40;  // 5 glyph pixels, 8 screen pixels each

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          pix_tick = 1'b0;
  logic          video_on = 1'b0;
  logic [CW-1:0] pixel_x = '0;
  logic [CW-1:0] pixel_y = '0;
  logic [CW-1:0] origin_x = '0;
  logic [CW-1:0] origin_y = '0;
  logic [2:0]    glyph_row_addr;
  logic [4:0]    glyph_row_data;
  logic          pixel_on;
  logic          drawing;

  logic [4:0] rom [8];
  assign glyph_row_data = rom[glyph_row_addr];

  glyph_renderer dut (
    .clk            (clk),
    .reset          (reset),
    .pix_tick       (pix_tick),
    .video_on       (video_on),
    .pixel_x        (pixel_x),
    .pixel_y        (pixel_y),
    .origin_x       (origin_x),
    .origin_y       (origin_y),
    .glyph_row_addr (glyph_row_addr),
    .glyph_row_data (glyph_row_data),
    .pixel_on       (pixel_on),
    .drawing        (drawing)
  );

  always #5 clk = ~clk;

  typedef struct {
    int pon;
    int drw;
    int addr;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   mon_en  = 1'b0;

  // Model: the line's glyph is live from its x=0 load until video_on drops or a reset.
  bit         m_active = 1'b0;
  int         m_lx     = 0;
  logic [4:0] m_row    = '0;
  int         m_pon    = 0;
  int         m_drw    = 0;

  int cur_ox, cur_oy, alt_ox, alt_oy, chg_x;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_tests++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
    end
  endtask

  task automatic step(input int x, input int y, input bit vo, input bit tick, input bit rst);
    exp_t e;
    int   ox, oy;
    bit   in_band;
    @(negedge clk);
    ox = (chg_x >= 0 && x >= chg_x) ? alt_ox : cur_ox;
    oy = (chg_x >= 0 && x >= chg_x) ? alt_oy : cur_oy;
    reset    = rst;
    pix_tick = tick;
    video_on = vo;
    pixel_x  = CW'(x);
    pixel_y  = CW'(y);
    origin_x = CW'(ox);
    origin_y = CW'(oy);
    in_band  = (y >= oy) && (y < oy + BOX);
    if (rst) begin
      m_active = 1'b0;
      m_pon    = 0;
      m_drw    = 0;
    end else if (tick) begin
      if (!vo) m_active = 1'b0;
      else if (x == 0) begin
        m_active = in_band;
        if (in_band) begin
          m_lx  = ox;
          m_row = rom[(y - oy) / 8];
        end
      end
      if (m_active && x >= m_lx && x < m_lx + BOX) begin
        m_drw = 1;
        m_pon = int'(m_row[4 - (x - m_lx) / 8]);
      end else begin
        m_drw = 0;
        m_pon = 0;
      end
    end
    e.pon  = m_pon;
    e.drw  = m_drw;
    e.addr = in_band ? (y - oy) / 8 : 0;
    exp_q.push_back(e);
    mon_en = 1'b1;
  endtask

  task automatic run_line(input int y, input bit vis, input int drop_x, input int rst_x,
                          input bit alt);
    bit vo;
    for (int x = 0; x < H_TOT; x++) begin
      vo = vis && (x < H_VIS) && !(drop_x >= 0 && x >= drop_x);
      if (x == rst_x) step(x, y, vo, 1'b0, 1'b1);
      if (alt) step(x, y, vo, 1'b0, 1'b0);
      else repeat ($urandom_range(0, 2)) step(x, y, vo, 1'b0, 1'b0);
      step(x, y, vo, 1'b1, 1'b0);
    end
  endtask

  exp_t mon_e;
  int   mon_addr;

  always begin
    @(posedge clk);
    if (mon_en) begin
      mon_addr = int'(glyph_row_addr);
      #1;
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL scoreboard: got empty queue expected an entry at %0t", $time);
      end else begin
        mon_e = exp_q.pop_front();
        check("row_addr", mon_addr, mon_e.addr);
        check("pixel_on", pixel_on, mon_e.pon);
        check("drawing", drawing, mon_e.drw);
      end
    end
  end

  initial begin
    int y;
    rom    = '{5'b00100, 5'b00100, 5'b11111, 5'b00100, 5'b00100, 5'b0, 5'b0, 5'b0};
    chg_x  = -1;
    alt_ox = 0;
    alt_oy = 0;
    cur_ox = 100;
    cur_oy = 200;

    step(0, 0, 1'b0, 1'b0, 1'b1);
    step(0, 0, 1'b1, 1'b1, 1'b1);

    run_line(216, 1'b1, -1, -1, 1'b1);   // full row 11111
    run_line(200, 1'b1, -1, -1, 1'b1);   // row 0, centre column only
    run_line(199, 1'b1, -1, -1, 1'b1);   // just above band
    run_line(240, 1'b1, -1, -1, 1'b1);   // just below band

    cur_ox = 0;
    cur_oy = 0;
    run_line(20, 1'b1, -1, -1, 1'b1);    // direct IDLE->DRAW at x=0

    cur_ox = 100;
    cur_oy = 200;
    run_line(216, 1'b1, 110, -1, 1'b1);  // video_on abort mid-draw
    run_line(216, 1'b1, -1, -1, 1'b1);
    run_line(216, 1'b1, -1, 105, 1'b1);  // reset mid-draw with pix_tick low
    run_line(216, 1'b1, -1, -1, 1'b1);
    run_line(216, 1'b0, -1, -1, 1'b1);   // vertical blanking line

    cur_ox = 150;
    run_line(216, 1'b1, -1, -1, 1'b0);   // box truncated at right edge
    cur_ox = 100;
    cur_oy = 1000;
    run_line(1020, 1'b1, -1, -1, 1'b0);  // band crosses top of coordinate range
    cur_oy = 200;
    chg_x  = 50;
    alt_ox = 20;
    alt_oy = 0;
    run_line(216, 1'b1, -1, -1, 1'b0);   // origin moved mid-line
    chg_x  = -1;

    for (int n = 0; n < 50; n++) begin
      for (int r = 0; r < 5; r++) rom[r] = 5'($urandom);
      cur_ox = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, H_VIS + 10));
      cur_oy = int'($urandom_range(0, 1023));
      y      = cur_oy + int'($urandom_range(0, 48)) - 4;
      if (y < 0) y = 0;
      if (y > 1023) y = 1023;
      chg_x  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, H_VIS)) : -1;
      alt_ox = int'($urandom_range(0, H_VIS));
      alt_oy = int'($urandom_range(0, 1023));
      run_line(y, $urandom_range(0, 9) != 0,
               ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, H_VIS)) : -1,
               ($urandom_range(0, 15) == 0) ? int'($urandom_range(1, H_VIS)) : -1,
               $urandom_range(0, 2) == 0);
    end

    @(posedge clk);
    #2;
    mon_en = 1'b0;
    check("queue_drain", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/glyph_renderer.md
Name: glyph_renderer

Overview:
- Downstream consumer of the 5x5 glyph-row ROMs (e.g. the "+" symbol ROM) in the VGA calculator display.
- Watches the VGA pixel scan and, while the beam is inside a glyph box at (origin_x, origin_y), drives the ROM row address.
- Latches the returned 5-bit row pattern and serialises it MSB-first, scaling each glyph pixel to 2^SCALE_LOG2 x 2^SCALE_LOG2 screen pixels.
- Produces a registered pixel_on for the colour mux.

Parameters:
- GLYPH_W, 5: glyph columns (row data width).
- GLYPH_H, 5: glyph rows.
- SCALE_LOG2, 3: log2 of the screen-pixel size of one glyph pixel (default gives an 8x8 block).
- CW, 10: width of the pixel_x, pixel_y, origin_x and origin_y coordinates.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- pix_tick  in  1  pixel enable; all state advances only when high
- video_on  in  1  VGA visible-area flag
- pixel_x  in  CW  current scan column
- pixel_y  in  CW  current scan row
- origin_x  in  CW  glyph box left edge
- origin_y  in  CW  glyph box top edge
- glyph_row_addr  out  3  row index to glyph ROM in_row (combinational)
- glyph_row_data  in  GLYPH_W  row pattern from glyph ROM out_code (combinational ROM)
- pixel_on  out  1  registered glyph pixel, bit 4 = leftmost
- drawing  out  1  high while state = DRAW

Behaviour:
- One clock domain. Reset is synchronous and active-high. Reset clears state to IDLE, pixel_on=0, row_buf=0, sub_cnt=0, bit_cnt=0, x_lat=0.
- Band arithmetic uses CW+1 bits, so there is no overflow:
  - in_band = (pixel_y >= origin_y) && (pixel_y < origin_y + (GLYPH_H << SCALE_LOG2)).
  - glyph_row_addr = ((pixel_y - origin_y) >> SCALE_LOG2)[2:0] when in_band, else 0.
- All transitions below occur only on clk edges with pix_tick=1. With pix_tick=0, every register holds.
- State IDLE:
  - If pixel_x==0, video_on and in_band: load row_buf <= glyph_row_data and x_lat <= origin_x.
  - If origin_x==0, go directly to DRAW with pixel_on <= glyph_row_data[4], sub_cnt=1, bit_cnt=0.
  - Otherwise go to ARMED with pixel_on <= 0.
  - In every other IDLE case, pixel_on <= 0.
- State ARMED:
  - When pixel_x == x_lat: go to DRAW with pixel_on <= row_buf[4], sub_cnt=1, bit_cnt=0.
  - When pixel_x==0, return to IDLE and re-evaluate on the next tick. This covers an origin off the visible line.
  - pixel_on stays 0 while ARMED.
- State DRAW, each tick:
  - pixel_on <= row_buf[4-bit_cnt] and sub_cnt++.
  - When sub_cnt wraps from 2^SCALE_LOG2-1 to 0, bit_cnt++.
  - After exactly GLYPH_W << SCALE_LOG2 ticks in DRAW (counting the entry tick), the next tick goes to IDLE with pixel_on <= 0.
- Latency: pixel_on reflects the pixel_x sampled on the previous pix_tick, i.e. one pixel late. The downstream colour mux applies a matching one-tick delay to its sync signals.
- video_on low in any state forces IDLE and pixel_on <= 0 on that tick. This aborts a draw.
- Origin changes take effect only at the next pixel_x==0 load. Mid-line changes do not affect an in-progress draw.
- A glyph box extending past the visible width is truncated by the video_on abort. No wrap to the next line.
- drawing = (state==DRAW), combinational from the state register.
- Reset asserted mid-DRAW: the next clock gives IDLE and pixel_on=0, regardless of pix_tick.

Test Plan:
- origin=(100,200), "+" ROM, pix_tick every 2nd clk, scan line y=216 (row 2, 11111) -> pixel_on=1 for exactly the ticks after x=100..139 (40 ticks), 0 elsewhere; glyph_row_addr=2.
- Same origin, line y=200 (row 0, 00100) -> pixel_on=1 only for ticks after x=116..123; glyph_row_addr=0; drawing high for 40 ticks.
- Lines y=199 and y=240 (outside band) -> state never leaves IDLE; pixel_on=0 on whole line; glyph_row_addr=0.
- origin=(0,0), line y=20 (row 2) -> direct IDLE->DRAW at x=0; pixel_on=1 for ticks after x=0..39.
- video_on dropped at x=110 while drawing row 2 -> pixel_on=0 from that tick and state IDLE; the next line draws normally.
- reset pulsed one clk at x=105 mid-draw, pix_tick held low -> pixel_on=0 and drawing=0 on the next clk; no output for the rest of that line.
